scan_chain_loader: RTL and testbench
====================================

// Module: scan_chain_loader
// PURPOSE
//  Byte-to-serial programmer for the memory_bank scan chain (memory cells, btn,
//  LED, locking key). Takes host bytes over valid/ready and shifts them into the
//  chain via scan_enable/scan_in. Holds the CPU halted while loading. Can return
//  the previous chain contents captured from scan_out.
// PARAMETERS
//  CHAIN_LEN  144  total chain bits (15*8 mem + 1 btn + 7 LED + 16 key)
//  CNT_W      $clog2(CHAIN_LEN+1)  bit-counter width (derived, do not override)
// PORTS
//  clk          in   1  single clock; all logic on posedge
//  rst          in   1  synchronous, active-low reset
//  start        in   1  one-cycle pulse: begin a load session
//  abort        in   1  one-cycle pulse: cancel the session
//  in_data      in   8  host byte; first bit sent is bit 7
//  in_valid     in   1  in_data valid
//  in_ready     out  1  loader accepts in_data this cycle
//  scan_enable  out  1  to memory_bank.scan_enable
//  scan_in      out  1  to memory_bank.scan_in
//  scan_out     in   1  from memory_bank.scan_out
//  cpu_halt     out  1  high from start until done/abort; freezes CPU writes
//  busy         out  1  session in progress
//  done         out  1  one-cycle pulse after the last chain bit is shifted
//  out_data     out  8  readback byte (SCAN_LOADER_READBACK_EN only)
//  out_valid    out  1  readback byte valid (SCAN_LOADER_READBACK_EN only)
//  out_ready    in   1  host takes readback byte (SCAN_LOADER_READBACK_EN only)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE. in_ready, scan_enable, scan_in,
//    cpu_halt, busy, done and out_valid are 0. out_data is 0. Counters are 0.
//  - FSM IDLE -> FILL -> SHIFT -> (FILL | DRAIN | FINISH) -> IDLE.
//  - IDLE: start=1 -> FILL next cycle. bit_cnt=0. busy and cpu_halt are 1 from
//    that edge. start while not IDLE is ignored.
//  - FILL: in_ready=1. When in_valid&in_ready, the byte is latched into tx_sr
//    and the state moves to SHIFT. in_ready is 0 in every other state.
//  - SHIFT: each cycle scan_enable=1, scan_in=tx_sr[7], tx_sr<<=1, bit_cnt++.
//    rx_sr captures scan_out in the same cycle (MSB first).
//    - After 8 bits: go to FILL (or DRAIN with readback).
//    - When bit_cnt reaches CHAIN_LEN: stop immediately and go to FINISH. Any
//      unshifted bits of the final byte are discarded.
//    - Total bytes are ceil(CHAIN_LEN/8). The first bit sent ends at the
//      scan_out end of the chain.
//  - scan_enable is 0 in all non-SHIFT states. A host stall between bytes
//    therefore lets the btn cell resample btn_in. This is accepted.
//  - FINISH: done=1 for exactly one cycle. busy and cpu_halt drop on the same
//    edge that returns the state to IDLE.
//  - abort in any non-IDLE state: IDLE next cycle. scan_enable=0, busy=0,
//    cpu_halt=0, out_valid=0. No done pulse. Chain contents are undefined
//    (partial shift). abort has priority over start, in_valid and out_ready.
//  - Reset mid-session behaves as abort and also clears out_data.
// CONFIGURATION
//  SCAN_LOADER_READBACK_EN defined:
//    - After each 8 captured bits, and after a final partial byte, present
//      rx_sr on out_data with out_valid=1. A partial byte is zero-padded in its
//      low bits.
//    - DRAIN holds (no shifting) until out_valid&out_ready, then continues.
//    - The last readback byte must be taken before FINISH.
//  SCAN_LOADER_READBACK_EN undefined:
//    - No rx_sr and no DRAIN state. out_data=0, out_valid=0, out_ready ignored.
// TESTING
//  1 Reset: rst=0 for 2 cycles -> all outputs 0, in_ready=0.
//  2 Full load: start, then 18 bytes 0x00..0x11 with in_valid always 1 ->
//    144 scan_enable cycles, 18 FILL cycles, done at cycle 163 after start,
//    locking_key==16'h1011 in the attached memory_bank.
//  3 Host stall: hold in_valid=0 for 5 cycles before byte 3 -> scan_enable=0
//    during the stall, final chain identical to test 2.
//  4 Truncation: CHAIN_LEN=13, bytes 0xAB,0xFF -> exactly 13 shifts; the last
//    3 bits of 0xFF are dropped; done pulses once.
//  5 Abort: abort after byte 5 -> next cycle busy=0, cpu_halt=0, no done.
//    A following start runs a clean session.
//  6 Readback (EN): preload chain with test 2 pattern, then load all-0xFF ->
//    out bytes 0x00..0x11 in order; out_ready low 4 cycles stalls shifting.

Source files
------------

// File: rtl/scan_chain_loader.sv
// Byte-to-serial loader for the memory_bank scan chain; halts the CPU while a session runs.
// Optional readback of the previous chain contents is enabled by SCAN_LOADER_READBACK_EN.
module scan_chain_loader #(
  parameter  int CHAIN_LEN = 144,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       cpu_halt,
  output logic       busy,
  output logic       done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

`ifdef SCAN_LOADER_READBACK_EN
  typedef enum logic [2:0] {IDLE, FILL, SHIFT, DRAIN, FINISH} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, SHIFT, FINISH} state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       tx_q, tx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SCAN_LOADER_READBACK_EN
  logic [7:0] rx_q, rx_d;
  logic [7:0] od_q, od_d;
  logic [2:0] pad;
`else
  logic unused_rb;
  assign unused_rb = out_ready ^ scan_out;
`endif

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    cnt_d       = cnt_q;
    in_ready    = 1'b0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    done        = 1'b0;
`ifdef SCAN_LOADER_READBACK_EN
    rx_d        = rx_q;
    od_d        = od_q;
    pad         = 3'd0;
    out_valid   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tx_d    = in_data;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scan_enable = 1'b1;
        scan_in     = tx_q[7];
        tx_d        = {tx_q[6:0], 1'b0};
        cnt_d       = cnt_q + 1'b1;
`ifdef SCAN_LOADER_READBACK_EN
        rx_d = {rx_q[6:0], scan_out};
        // A truncated last byte is left-justified so its bits keep their MSB-first order.
        pad  = 3'd0 - cnt_d[2:0];
        if (cnt_d == CNT_W'(CHAIN_LEN)) begin
          od_d    = rx_d << pad;
          state_d = DRAIN;
        end else if (cnt_d[2:0] == 3'd0) begin
          od_d    = rx_d;
          state_d = DRAIN;
        end
`else
        if (cnt_d == CNT_W'(CHAIN_LEN))
          state_d = FINISH;
        else if (cnt_d[2:0] == 3'd0)
          state_d = FILL;
`endif
      end
`ifdef SCAN_LOADER_READBACK_EN
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = (cnt_q == CNT_W'(CHAIN_LEN)) ? FINISH : FILL;
      end
`endif
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over every handshake in the same cycle.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      in_ready = 1'b0;
      done     = 1'b0;
      tx_d     = tx_q;
`ifdef SCAN_LOADER_READBACK_EN
      out_valid = 1'b0;
      od_d      = od_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      cnt_q   <= '0;
`ifdef SCAN_LOADER_READBACK_EN
      rx_q    <= '0;
      od_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
`ifdef SCAN_LOADER_READBACK_EN
      rx_q    <= rx_d;
      od_q    <= od_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign cpu_halt = busy;

`ifdef SCAN_LOADER_READBACK_EN
  assign out_data = od_q;
`else
  assign out_data  = 8'h00;
  assign out_valid = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: a 144-bit and a 13-bit loader share host inputs, each
// feeding a shift-register stand-in for memory_bank; chains are checked against byte lists.
module tb_scan_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;

  logic       a_rdy, a_se, a_si, a_so, a_halt, a_busy, a_done, a_ov;
  logic [7:0] a_od;
  logic       b_rdy, b_se, b_si, b_so, b_halt, b_busy, b_done, b_ov;
  logic [7:0] b_od;

  scan_chain_loader #(.CHAIN_LEN(144)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_rdy),
    .scan_enable(a_se), .scan_in(a_si), .scan_out(a_so),
    .cpu_halt(a_halt), .busy(a_busy), .done(a_done),
    .out_data(a_od), .out_valid(a_ov), .out_ready(out_ready));

  scan_chain_loader #(.CHAIN_LEN(13)) dut13 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_rdy),
    .scan_enable(b_se), .scan_in(b_si), .scan_out(b_so),
    .cpu_halt(b_halt), .busy(b_busy), .done(b_done),
    .out_data(b_od), .out_valid(b_ov), .out_ready(out_ready));

  // Chain stand-ins: bit [LEN-1] drives scan_out, new bits enter at [0].
  logic [143:0] ch_a = '0;
  logic [12:0]  ch_b = '0;
  assign a_so = ch_a[143];
  assign b_so = ch_b[12];

  int cyc = 0, sh_a = 0, sh_b = 0, dn_a = 0, dn_b = 0, fill_a = 0, rb_n = 0;
  logic [7:0] rb [0:255];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_se) begin ch_a <= {ch_a[142:0], a_si}; sh_a <= sh_a + 1; end
    if (b_se) begin ch_b <= {ch_b[11:0], b_si}; sh_b <= sh_b + 1; end
    if (a_done) dn_a <= dn_a + 1;
    if (b_done) dn_b <= dn_b + 1;
    if (a_rdy) fill_a <= fill_a + 1;
    if (a_ov && out_ready && rb_n < 256) begin rb[rb_n] <= a_od; rb_n <= rb_n + 1; end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] pay [0:17];
  int         stl [0:17];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int w = 0;
    while (!a_rdy && w < 60) begin tick(); w++; end
    chk("rdy_wait", a_rdy, 1);
    repeat (stall) begin
      in_valid = 1'b0;
      tick();
      chk("stall_no_shift", {a_se, a_rdy}, 2'b01);
    end
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (!a_done && w < 60) begin tick(); w++; end
    chk({tag, "_done_seen"}, a_done, 1);
  endtask

  // Expected chain: bit i of the session stream (MSB-first) ends at position LEN-1-i.
  task automatic run_full(input string tag);
    int t0, s0, f0, d0, stot, drain;
    logic [143:0] exp;
    stot  = 0;
    drain = 0;
`ifdef SCAN_LOADER_READBACK_EN
    drain = 18;
`endif
    s0 = sh_a; f0 = fill_a; d0 = dn_a;
    do_start();
    t0 = cyc;
    chk({tag, "_busy_halt"}, {a_busy, a_halt}, 2'b11);
    for (int i = 0; i < 18; i++) begin
      send_byte(pay[i], stl[i]);
      stot += stl[i];
    end
    wait_done(tag);
    chk({tag, "_latency"}, cyc - t0, 18 + stot + 144 + drain);
    chk({tag, "_busy_at_done"}, {a_busy, a_halt}, 2'b11);
    tick();
    chk({tag, "_idle_after"}, {a_done, a_busy, a_halt}, 3'b000);
    chk({tag, "_shifts"}, sh_a - s0, 144);
    chk({tag, "_fill_cycles"}, fill_a - f0, 18 + stot);
    chk({tag, "_done_count"}, dn_a - d0, 1);
    for (int i = 0; i < 144; i++) exp[143 - i] = pay[i / 8][7 - (i % 8)];
    chk({tag, "_chain"}, ch_a, exp);
  endtask

  initial begin
    int s0, d0, r0, w;

    // Reset
    tick(); tick();
    chk("rst_a_outs", {a_rdy, a_se, a_si, a_halt, a_busy, a_done, a_ov}, 7'b0);
    chk("rst_a_odata", a_od, 8'h00);
    chk("rst_b_outs", {b_rdy, b_se, b_halt, b_busy, b_done, b_ov}, 6'b0);
    do_start();
    chk("start_in_reset_ignored", {a_busy, a_rdy}, 2'b00);
    rst = 1'b1;
    tick();

    // Full load of 0x00..0x11 without stalls
    for (int i = 0; i < 18; i++) begin pay[i] = 8'(i); stl[i] = 0; end
    run_full("full");
    chk("full_key", ch_a[15:0], 16'h1011);

    // Same data with a 5-cycle host stall before byte 3
    stl[3] = 5;
    run_full("stall");
    chk("stall_key", ch_a[15:0], 16'h1011);
    stl[3] = 0;

`ifdef SCAN_LOADER_READBACK_EN
    // Readback of the 0x00..0x11 pattern while loading all-ones
    r0 = rb_n;
    out_ready = 1'b0;
    do_start();
    send_byte(8'hFF, 0);
    w = 0;
    while (!a_ov && w < 30) begin tick(); w++; end
    chk("rb_first_valid", a_ov, 1);
    repeat (4) begin
      chk("rb_hold", {a_se, a_ov, a_rdy}, 3'b010);
      chk("rb_hold_data", a_od, 8'h00);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 18; i++) send_byte(8'hFF, 0);
    wait_done("rb");
    tick();
    chk("rb_count", rb_n - r0, 18);
    for (int i = 0; i < 18; i++) chk("rb_byte", rb[r0 + i], 8'(i));
    chk("rb_chain_ones", ch_a, {144{1'b1}});
`endif

    // Truncation on the 13-bit loader: 0xAB then 5 bits of 0xFF
    s0 = sh_b; d0 = dn_b;
    do_start();
    send_byte(8'hAB, 0);
    send_byte(8'hFF, 0);
    w = 0;
    while (!b_done && w < 30) begin tick(); w++; end
    chk("trunc_done_seen", b_done, 1);
    repeat (6) tick();
    chk("trunc_shifts", sh_b - s0, 13);
    chk("trunc_done_once", dn_b - d0, 1);
    chk("trunc_chain", ch_b, {8'hAB, 5'b11111});
    chk("trunc_idle", {b_busy, b_halt, b_rdy}, 3'b000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("trunc_abort_a", {a_busy, a_halt}, 2'b00);

    // Abort after byte 5 while shifting
    d0 = dn_a;
    do_start();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    tick(); tick();
    chk("abort_pre_shift", a_se, 1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_outs", {a_busy, a_halt, a_se, a_rdy, a_ov}, 5'b0);
    repeat (30) tick();
    chk("abort_no_done", dn_a - d0, 0);
    chk("abort_still_idle", a_busy, 0);

    // Clean randomized sessions after the abort
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 18; i++) begin
        pay[i] = 8'($urandom);
        stl[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      end
      run_full("rand");
    end

    // Reset in the middle of a session
    do_start();
    send_byte(8'h5A, 0);
    send_byte(8'hC3, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_outs", {a_busy, a_halt, a_se, a_rdy, a_done, a_ov}, 6'b0);
    chk("midrst_odata", a_od, 8'h00);
    tick();
    chk("midrst_stays_idle", a_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
